control_fsm: RTL and testbench
==============================

CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have port: clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: opcode  input  4  instruction bits [15:12] from the instruction register.
REQ-004 SHALL have port: carry  input  1  ALU carry-out of the current ALU operation.
REQ-005 SHALL have port: outA  input  16  latched operand-A value.
REQ-006 SHALL have ports: pc_rst, pc_wrt, addr_sel, ir_wrt, rega_sel, reg_wrt, opa_sel, re, we  output  1 each  datapath strobes and selects.
REQ-007 SHALL have ports: data_sel  output  2; opb_sel  output  2; alu_sel  output  3  datapath selects.
REQ-008 SHALL have port: halted  output  1  high while in HALT.

Function
REQ-009 SHALL be a Moore FSM with states RESET, FETCH, DECODE, EXEC, MEM, WB, BRANCH, HALT; all outputs decoded from registered state, opcode and registered flags only.
REQ-010 SHALL default every output to 0 in any state that does not drive it explicitly.
REQ-011 RESET: pc_rst=1; next state FETCH.
REQ-012 FETCH: addr_sel=0, re=1, ir_wrt=1, opa_sel=1, opb_sel=2 (one), alu_sel=000 (ADD); next DECODE.
REQ-013 DECODE: pc_wrt=1 (PC <= PC+1 from the ALU output register); rega_sel=1 for opcodes 0xA, 0xB and 0xD, otherwise 0; next EXEC, except 0xE goes to FETCH and 0xF goes to HALT.
REQ-014 Opcode map: 0x0-0x7 = ALU R-type, alu_sel=opcode[2:0]; 0x8 LI; 0x9 LW; 0xA SW; 0xB BZ; 0xC JMP; 0xD BC (see Configuration); 0xE NOP; 0xF HALT.
REQ-015 EXEC, R-type: opa_sel=0, opb_sel=0, alu_sel=opcode[2:0]; the carry input is captured into the internal carry flag at the end of this cycle; next WB.
REQ-016 EXEC, LI: data_sel=0, reg_wrt=1; next FETCH (3-cycle instruction).
REQ-017 EXEC, LW: addr_sel=1, re=1; next MEM.
REQ-018 EXEC, SW: addr_sel=1, we=1; next FETCH.
REQ-019 EXEC, BZ/JMP/BC: opa_sel=1, opb_sel=3 (offset), alu_sel=000; next BRANCH.
REQ-020 The BZ condition SHALL be sampled from outA==16'h0000 during EXEC and registered as the take flag.
REQ-021 MEM (LW): data_sel=1, reg_wrt=1; next FETCH.
REQ-022 WB (R-type): data_sel=2, reg_wrt=1; next FETCH (4-cycle instruction).
REQ-023 BRANCH: pc_wrt=1 iff JMP, or BZ with take flag=1, or BC with carry flag=1; next FETCH; a not-taken branch leaves PC at PC+1.
REQ-024 HALT SHALL be absorbing: halted=1 and all strobes 0 until rst_n is asserted.
REQ-025 re and we SHALL never both be 1 in the same cycle; ir_wrt SHALL be 1 only in FETCH.
REQ-026 Any opcode not enabled (0xD without the macro) SHALL behave as NOP.

Reset
REQ-027 rst_n=0 SHALL immediately force state RESET and clear the carry flag and take flag, independent of clk, including mid-instruction; any write strobe in progress SHALL drop in the same cycle.
REQ-028 During reset all outputs SHALL be 0 except pc_rst=1; the first FETCH occurs one clock after rst_n rises.

Configuration
REQ-029 Macro CTRL_CARRY_BRANCH_EN defined: opcode 0xD = BC, branch taken on the carry flag captured by the most recent R-type instruction.
REQ-030 CTRL_CARRY_BRANCH_EN undefined: the carry flag register is omitted, the carry input is unused, and 0xD decodes as NOP (DECODE -> FETCH).

Verification
REQ-031 Release reset, opcode=0x0 -> states RESET, FETCH, DECODE, EXEC, WB, FETCH; in WB reg_wrt=1 and data_sel=2; in EXEC alu_sel=000.
REQ-032 opcode=0x9 -> in EXEC addr_sel=1 and re=1; in MEM reg_wrt=1 and data_sel=1; back in FETCH after 4 cycles.
REQ-033 opcode=0xB with outA=16'h0000 -> pc_wrt=1 in BRANCH; with outA=16'h0001 -> pc_wrt=0 in BRANCH.
REQ-034 Macro defined: R-type with carry=1, then 0xD -> pc_wrt=1 in BRANCH; macro undefined: 0xD -> DECODE then FETCH with no EXEC.
REQ-035 opcode=0xF -> halted=1 held for 20 cycles with all strobes 0; pulse rst_n low -> pc_rst=1 and halted=0 immediately.
REQ-036 Assert rst_n low during SW EXEC -> we falls to 0 without waiting for a clock edge, and the FSM restarts in FETCH.

Source files
------------

// File: rtl/control_fsm.sv
// control_fsm -- multi-cycle processor control unit (Moore FSM).
//
// Sequences a small 16-bit datapath through
// RESET -> FETCH -> DECODE -> EXEC -> (MEM | WB | BRANCH) -> FETCH.
// HALT is absorbing until rst_n is asserted. Every output is decoded from
// the registered state, the opcode and the registered flags. Because
// rst_n forces the state register asynchronously, every strobe drops as
// soon as reset is asserted, including mid-instruction.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   opcode    in   [3:0] instruction bits [15:12]
//   carry     in   ALU carry-out (used only with CTRL_CARRY_BRANCH_EN)
//   outA      in   [15:0] latched operand A (zero test for BZ)
//   pc_rst, pc_wrt, addr_sel, ir_wrt, rega_sel, reg_wrt, opa_sel, re, we
//             out  datapath strobes and selects
//   data_sel  out  [1:0] register-file write data select
//   opb_sel   out  [1:0] ALU operand-B select
//   alu_sel   out  [2:0] ALU function select
//   halted    out  high while in HALT
//
// Build option: define CTRL_CARRY_BRANCH_EN to enable opcode 0xD (BC,
// branch on the carry captured by the last R-type instruction). Without
// it, 0xD decodes as NOP and the carry input is ignored.
module control_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  opcode,
  input  logic        carry,
  input  logic [15:0] outA,
  output logic        pc_rst,
  output logic        pc_wrt,
  output logic        addr_sel,
  output logic        ir_wrt,
  output logic        rega_sel,
  output logic        reg_wrt,
  output logic        opa_sel,
  output logic        re,
  output logic        we,
  output logic [1:0]  data_sel,
  output logic [1:0]  opb_sel,
  output logic [2:0]  alu_sel,
  output logic        halted
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_BRANCH = 3'd6,
    ST_HALT   = 3'd7
  } state_t;

  localparam logic [3:0] OP_LI   = 4'h8;
  localparam logic [3:0] OP_LW   = 4'h9;
  localparam logic [3:0] OP_SW   = 4'hA;
  localparam logic [3:0] OP_BZ   = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_BC   = 4'hD;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t state_r;
  state_t next_state_s;
  logic   take_flag_r;
  logic   carry_flag_s;

`ifdef CTRL_CARRY_BRANCH_EN
  localparam logic BC_EN = 1'b1;
  logic carry_flag_r;

  // Carry flag: captured at the end of an R-type EXEC cycle only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_flag_r <= 1'b0;
    end else if (state_r == ST_EXEC && opcode[3] == 1'b0) begin
      carry_flag_r <= carry;
    end else begin
      carry_flag_r <= carry_flag_r;
    end
  end

  assign carry_flag_s = carry_flag_r;
`else
  localparam logic BC_EN = 1'b0;
  logic unused_carry_s;

  assign unused_carry_s = carry;
  assign carry_flag_s   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RESET;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Take flag: BZ zero test on operand A, sampled at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      take_flag_r <= 1'b0;
    end else if (state_r == ST_EXEC && opcode == OP_BZ) begin
      take_flag_r <= (outA == 16'h0000);
    end else begin
      take_flag_r <= take_flag_r;
    end
  end

  // Next-state and Moore output decode; every output defaults to 0.
  always_comb begin
    next_state_s = ST_RESET;
    pc_rst       = 1'b0;
    pc_wrt       = 1'b0;
    addr_sel     = 1'b0;
    ir_wrt       = 1'b0;
    rega_sel     = 1'b0;
    reg_wrt      = 1'b0;
    opa_sel      = 1'b0;
    re           = 1'b0;
    we           = 1'b0;
    data_sel     = 2'd0;
    opb_sel      = 2'd0;
    alu_sel      = 3'b000;
    halted       = 1'b0;

    case (state_r)
      ST_RESET: begin
        pc_rst       = 1'b1;
        next_state_s = ST_FETCH;
      end

      // IR <= mem[PC] while the ALU forms PC + 1.
      ST_FETCH: begin
        addr_sel     = 1'b0;
        re           = 1'b1;
        ir_wrt       = 1'b1;
        opa_sel      = 1'b1;
        opb_sel      = 2'd2;
        alu_sel      = 3'b000;
        next_state_s = ST_DECODE;
      end

      ST_DECODE: begin
        pc_wrt   = 1'b1;
        rega_sel = (opcode == OP_SW) || (opcode == OP_BZ) ||
                   (BC_EN && (opcode == OP_BC));
        case (opcode)
          OP_NOP:  next_state_s = ST_FETCH;
          OP_HALT: next_state_s = ST_HALT;
          OP_BC:   next_state_s = BC_EN ? ST_EXEC : ST_FETCH;
          default: next_state_s = ST_EXEC;
        endcase
      end

      ST_EXEC: begin
        case (opcode)
          4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
            opa_sel      = 1'b0;
            opb_sel      = 2'd0;
            alu_sel      = opcode[2:0];
            next_state_s = ST_WB;
          end
          OP_LI: begin
            data_sel     = 2'd0;
            reg_wrt      = 1'b1;
            next_state_s = ST_FETCH;
          end
          OP_LW: begin
            addr_sel     = 1'b1;
            re           = 1'b1;
            next_state_s = ST_MEM;
          end
          OP_SW: begin
            addr_sel     = 1'b1;
            we           = 1'b1;
            next_state_s = ST_FETCH;
          end
          OP_BZ, OP_JMP, OP_BC: begin
            // Branch target = PC + offset. BC only reaches EXEC when enabled.
            opa_sel      = 1'b1;
            opb_sel      = 2'd3;
            alu_sel      = 3'b000;
            next_state_s = ST_BRANCH;
          end
          default: next_state_s = ST_FETCH;
        endcase
      end

      ST_MEM: begin
        data_sel     = 2'd1;
        reg_wrt      = 1'b1;
        next_state_s = ST_FETCH;
      end

      ST_WB: begin
        data_sel     = 2'd2;
        reg_wrt      = 1'b1;
        next_state_s = ST_FETCH;
      end

      // Not-taken branch: PC keeps the PC + 1 written in DECODE.
      ST_BRANCH: begin
        pc_wrt = (opcode == OP_JMP) ||
                 ((opcode == OP_BZ) && take_flag_r) ||
                 (BC_EN && (opcode == OP_BC) && carry_flag_s);
        next_state_s = ST_FETCH;
      end

      ST_HALT: begin
        halted       = 1'b1;
        next_state_s = ST_HALT;
      end

      default: next_state_s = ST_RESET;
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm -- self-checking bench for control_fsm.
// A table of per-cycle {opcode, carry, outA, expected outputs} rows is
// applied after reset; expected values go into a scoreboard queue when the
// row is driven and are popped and compared at the following falling edge.
// Hand-written sequences cover asynchronous reset out of HALT and during
// a SW execute cycle. Outputs are packed as
// {pc_rst, pc_wrt, addr_sel, ir_wrt, rega_sel, reg_wrt, opa_sel, re, we,
//  data_sel[1:0], opb_sel[1:0], alu_sel[2:0], halted}.
module tb_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  opcode = 4'h0;
  logic        carry = 1'b0;
  logic [15:0] outA = 16'h0000;
  logic        pc_rst, pc_wrt, addr_sel, ir_wrt, rega_sel, reg_wrt, opa_sel, re, we;
  logic [1:0]  data_sel, opb_sel;
  logic [2:0]  alu_sel;
  logic        halted;
  logic [16:0] dut_o;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [16:0] O_RST   = 17'h10000;
  localparam logic [16:0] O_FETCH = 17'h02620;
  localparam logic [16:0] O_DEC0  = 17'h08000;
  localparam logic [16:0] O_DEC1  = 17'h09000;
  localparam logic [16:0] O_WB    = 17'h00880;
  localparam logic [16:0] O_LI    = 17'h00800;
  localparam logic [16:0] O_LW    = 17'h04200;
  localparam logic [16:0] O_MEM   = 17'h00840;
  localparam logic [16:0] O_SW    = 17'h04100;
  localparam logic [16:0] O_EXB   = 17'h00430;
  localparam logic [16:0] O_BRT   = 17'h08000;
  localparam logic [16:0] O_BRN   = 17'h00000;
  localparam logic [16:0] O_HALT  = 17'h00001;

  typedef struct {
    logic [3:0]  op;
    logic        cy;
    logic [15:0] a;
    logic [16:0] exp;
    string       name;
  } vec_t;

  vec_t        tbl[$];
  logic [16:0] sb_q[$];

  control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .carry(carry), .outA(outA),
    .pc_rst(pc_rst), .pc_wrt(pc_wrt), .addr_sel(addr_sel), .ir_wrt(ir_wrt),
    .rega_sel(rega_sel), .reg_wrt(reg_wrt), .opa_sel(opa_sel), .re(re), .we(we),
    .data_sel(data_sel), .opb_sel(opb_sel), .alu_sel(alu_sel), .halted(halted)
  );

  assign dut_o = {pc_rst, pc_wrt, addr_sel, ir_wrt, rega_sel, reg_wrt, opa_sel,
                  re, we, data_sel, opb_sel, alu_sel, halted};

  always #5 clk = ~clk;

  function void add(input logic [3:0] op, input logic cy, input logic [15:0] a,
                    input logic [16:0] exp, input string name);
    vec_t v;
    v.op = op; v.cy = cy; v.a = a; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endfunction

  // R-type: carry presented in EXEC, a different carry presented in WB.
  function void add_rtype(input logic [3:0] op, input logic cy_ex, input logic cy_wb);
    logic [16:0] ex;
    ex = {13'd0, op[2:0], 1'b0};
    add(op, 1'b0, 16'h0000, O_FETCH, "r_fetch");
    add(op, 1'b0, 16'h0000, O_DEC0, "r_decode");
    add(op, cy_ex, 16'h0000, ex, "r_exec");
    add(op, cy_wb, 16'h0000, O_WB, "r_wb");
  endfunction

  task automatic compare(input string name);
    logic [16:0] exp;
    if (sb_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s: scoreboard empty, got %05h", name, dut_o);
    end else begin
      exp = sb_q.pop_front();
      n_cmp++;
      if (dut_o !== exp) begin
        n_err++;
        $display("FAIL %s: got %05h expected %05h", name, dut_o, exp);
      end
    end
  endtask

  task automatic run_cycle(input logic [3:0] op, input logic cy, input logic [15:0] a,
                           input logic [16:0] exp, input string name);
    @(posedge clk);
    #1;
    opcode = op; carry = cy; outA = a;
    sb_q.push_back(exp);
    @(negedge clk);
    compare(name);
  endtask

  task automatic check_now(input logic [16:0] exp, input string name);
    sb_q.push_back(exp);
    compare(name);
  endtask

  initial begin
    // Program.
    add_rtype(4'h0, 1'b0, 1'b0);
    add_rtype(4'h5, 1'b1, 1'b0);
    add(4'h8, 1'b0, 16'h0000, O_FETCH, "li_fetch");
    add(4'h8, 1'b0, 16'h0000, O_DEC0, "li_decode");
    add(4'h8, 1'b0, 16'h0000, O_LI, "li_exec");
    add(4'h9, 1'b0, 16'h0000, O_FETCH, "lw_fetch");
    add(4'h9, 1'b0, 16'h0000, O_DEC0, "lw_decode");
    add(4'h9, 1'b0, 16'h0000, O_LW, "lw_exec");
    add(4'h9, 1'b0, 16'h0000, O_MEM, "lw_mem");
    add(4'h0, 1'b0, 16'h0000, O_FETCH, "lw_back_fetch");
    add(4'h0, 1'b0, 16'h0000, O_DEC0, "lw_next_decode");
    add(4'h0, 1'b0, 16'h0000, 17'h00000, "lw_next_exec");
    add(4'h0, 1'b0, 16'h0000, O_WB, "lw_next_wb");
    add(4'hB, 1'b0, 16'h0000, O_FETCH, "bz0_fetch");
    add(4'hB, 1'b0, 16'h0000, O_DEC1, "bz0_decode");
    add(4'hB, 1'b0, 16'h0000, O_EXB, "bz0_exec");
    add(4'hB, 1'b0, 16'h0001, O_BRT, "bz0_branch_taken");
    add(4'hB, 1'b0, 16'h0001, O_FETCH, "bz1_fetch");
    add(4'hB, 1'b0, 16'h0001, O_DEC1, "bz1_decode");
    add(4'hB, 1'b0, 16'h0001, O_EXB, "bz1_exec");
    add(4'hB, 1'b0, 16'h0000, O_BRN, "bz1_branch_not_taken");
    add(4'hC, 1'b0, 16'h0001, O_FETCH, "jmp_fetch");
    add(4'hC, 1'b0, 16'h0001, O_DEC0, "jmp_decode");
    add(4'hC, 1'b0, 16'h0001, O_EXB, "jmp_exec");
    add(4'hC, 1'b0, 16'h0001, O_BRT, "jmp_branch");
    add(4'hE, 1'b0, 16'h0000, O_FETCH, "nop_fetch");
    add(4'hE, 1'b0, 16'h0000, O_DEC0, "nop_decode");
    // Carry = 1 from the R-type, then BC.
    add_rtype(4'h7, 1'b1, 1'b0);
    add(4'hD, 1'b0, 16'h0000, O_FETCH, "bc_a_fetch");
`ifdef CTRL_CARRY_BRANCH_EN
    add(4'hD, 1'b0, 16'h0000, O_DEC1, "bc_a_decode");
    add(4'hD, 1'b0, 16'h0000, O_EXB, "bc_a_exec");
    add(4'hD, 1'b0, 16'h0000, O_BRT, "bc_a_taken");
`else
    add(4'hD, 1'b0, 16'h0000, O_DEC0, "bc_a_nop_decode");
`endif
    // Carry = 0 in EXEC (carry = 1 only in WB must not be captured).
    add_rtype(4'h3, 1'b0, 1'b1);
    add(4'hD, 1'b1, 16'h0000, O_FETCH, "bc_b_fetch");
`ifdef CTRL_CARRY_BRANCH_EN
    add(4'hD, 1'b1, 16'h0000, O_DEC1, "bc_b_decode");
    add(4'hD, 1'b1, 16'h0000, O_EXB, "bc_b_exec");
    add(4'hD, 1'b1, 16'h0000, O_BRN, "bc_b_not_taken");
`else
    add(4'hD, 1'b1, 16'h0000, O_DEC0, "bc_b_nop_decode");
`endif
    add(4'hF, 1'b0, 16'h0000, O_FETCH, "halt_fetch");
    add(4'hF, 1'b0, 16'h0000, O_DEC0, "halt_decode");
    for (int i = 0; i < 20; i++) begin
      add((i % 2 == 0) ? 4'h9 : 4'hA, 1'b1, 16'h0000, O_HALT, "halt_hold");
    end

    // Reset phase.
    repeat (3) @(negedge clk);
    check_now(O_RST, "reset_state");
    rst_n = 1'b1;
    #1;
    check_now(O_RST, "reset_release");

    // Table.
    for (int i = 0; i < tbl.size(); i++) begin
      run_cycle(tbl[i].op, tbl[i].cy, tbl[i].a, tbl[i].exp, tbl[i].name);
    end

    // Async reset out of HALT, between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    check_now(O_RST, "halt_async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    check_now(O_RST, "halt_reset_release");
    run_cycle(4'hA, 1'b0, 16'h0000, O_FETCH, "restart_fetch");

    // Async reset during SW EXEC drops we at once.
    run_cycle(4'hA, 1'b0, 16'h0000, O_DEC1, "sw_decode");
    run_cycle(4'hA, 1'b0, 16'h0000, O_SW, "sw_exec");
    #2;
    rst_n = 1'b0;
    #1;
    check_now(O_RST, "sw_async_reset_we_drop");
    @(negedge clk);
    rst_n = 1'b1;
    run_cycle(4'h0, 1'b0, 16'h0000, O_FETCH, "sw_restart_fetch");

`ifdef CTRL_CARRY_BRANCH_EN
    // Reset clears the carry flag: set it, reset, then BC is not taken.
    run_cycle(4'h1, 1'b0, 16'h0000, O_DEC0, "cf_decode");
    run_cycle(4'h1, 1'b1, 16'h0000, 17'h00002, "cf_exec");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_now(O_RST, "cf_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_cycle(4'hD, 1'b0, 16'h0000, O_FETCH, "cf_fetch");
    run_cycle(4'hD, 1'b0, 16'h0000, O_DEC1, "cf_bc_decode");
    run_cycle(4'hD, 1'b0, 16'h0000, O_EXB, "cf_bc_exec");
    run_cycle(4'hD, 1'b0, 16'h0000, O_BRN, "cf_bc_cleared");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
